// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer and flag controller for a dual-clock FIFO, operating entirely in clk_r.
// The underflow flag is built only when FIFO_RD_UNDERFLOW_CHK_EN is defined; otherwise it is tied low.
module fifo_rd_ptr_ctrl #(
    parameter int  DEPTH       = 16,
    parameter int  AE_LEVEL    = 2,
    parameter int  SYNC_STAGES = 2,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          clk_r,
    input  logic          rst_r,
    input  logic          rd_en,
    input  logic [AW:0]   wptr_gray,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   rptr_gray,
    output logic          r_wrap,
    output logic          rd_valid,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   rd_count,
    output logic          underflow
);

    localparam logic [AW:0] AE_THRESH = (AW + 1)'(AE_LEVEL);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wsync_last;
    logic [AW:0] wbin;
    logic [AW:0] rbin_reg;
    logic [AW:0] rbin_next;
    logic [AW:0] rptr_gray_reg;
    logic        rd_valid_reg;
    logic        accept;

    // Write-pointer synchronizer: the first stage is the only sampler of wptr_gray.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [AW:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_r or posedge rst_r) begin
                    if (rst_r) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= wptr_gray;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk_r or posedge rst_r) begin
                    if (rst_r) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_sync[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign wsync_last = g_sync[SYNC_STAGES-1].stage_reg;

    // Binary bit i is the XOR of all Gray bits from i upwards.
    generate
        for (gi = 0; gi <= AW; gi++) begin : g_g2b
            assign wbin[gi] = ^wsync_last[AW:gi];
        end
    endgenerate

    // Occupancy and flags come only from registered pointers, so they move on clk_r edges.
    assign rd_count     = wbin - rbin_reg;
    assign empty        = (rd_count == '0);
    assign almost_empty = (rd_count <= AE_THRESH);

    assign accept    = rd_en & ~empty;
    assign rbin_next = accept ? (rbin_reg + PTR_ONE) : rbin_reg;

    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            rbin_reg      <= '0;
            rptr_gray_reg <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            rbin_reg      <= rbin_next;
            rptr_gray_reg <= rbin_next ^ (rbin_next >> 1);
            rd_valid_reg  <= accept;
        end
    end

    assign rptr      = rbin_reg[AW-1:0];
    assign r_wrap    = rbin_reg[AW];
    assign rptr_gray = rptr_gray_reg;
    assign rd_valid  = rd_valid_reg;

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    logic underflow_reg;

    // Sticky until reset: any read attempt while empty is recorded.
    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            underflow_reg <= 1'b0;
        end else begin
            underflow_reg <= underflow_reg | (rd_en & empty);
        end
    end

    assign underflow = underflow_reg;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed testbench for fifo_rd_ptr_ctrl with DEPTH=16, AE_LEVEL=2, SYNC_STAGES=2.
module tb_fifo_rd_ptr_ctrl;

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    logic       clk_r;
    logic       rst_r;
    logic       rd_en;
    logic [4:0] wptr_gray;
    logic [3:0] rptr;
    logic [4:0] rptr_gray;
    logic       r_wrap;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_count;
    logic       underflow;

    int n_cmp;
    int n_bad;

    fifo_rd_ptr_ctrl #(
        .DEPTH       (16),
        .AE_LEVEL    (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk_r        (clk_r),
        .rst_r        (rst_r),
        .rd_en        (rd_en),
        .wptr_gray    (wptr_gray),
        .rptr         (rptr),
        .rptr_gray    (rptr_gray),
        .r_wrap       (r_wrap),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow)
    );

    initial begin
        clk_r = 1'b0;
        forever #5 clk_r = ~clk_r;
    end

    task automatic tick();
        @(posedge clk_r);
        #1;
    endtask

    task automatic test_reset();
        rst_r = 1'b0; rd_en = 1'b0; wptr_gray = 5'b00000;
        #1 rst_r = 1'b1;
        #1;
        n_cmp++; if (rptr !== 4'd0) begin n_bad++; $display("FAIL reset_rptr: got %0d want 0", rptr); end
        n_cmp++; if (rptr_gray !== 5'b00000) begin n_bad++; $display("FAIL reset_rptr_gray: got %b want 00000", rptr_gray); end
        n_cmp++; if (r_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_r_wrap: got %b want 0", r_wrap); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
        n_cmp++; if (rd_count !== 5'd0) begin n_bad++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow: got %b want 0", underflow); end
        $display("reset: rptr=%0d empty=%b rd_count=%0d", rptr, empty, rd_count);
        rst_r = 1'b0;
    endtask

    task automatic test_sync_lag();
        wptr_gray = 5'b00111;
        tick();
        $display("sync edge1: empty=%b rd_count=%0d", empty, rd_count);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL lag_edge1_empty: got %b want 1", empty); end
        n_cmp++; if (rd_count !== 5'd0) begin n_bad++; $display("FAIL lag_edge1_count: got %0d want 0", rd_count); end
        tick();
        $display("sync edge2: empty=%b rd_count=%0d", empty, rd_count);
        n_cmp++; if (rd_count !== 5'd5) begin n_bad++; $display("FAIL lag_edge2_count: got %0d want 5", rd_count); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL lag_edge2_empty: got %b want 0", empty); end
        n_cmp++; if (almost_empty !== 1'b0) begin n_bad++; $display("FAIL lag_edge2_ae: got %b want 0", almost_empty); end
    endtask

    task automatic test_reads();
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("read %0d: rptr=%0d rd_valid=%b rd_count=%0d", i, rptr, rd_valid, rd_count);
            n_cmp++; if (rptr !== 4'(i + 1)) begin n_bad++; $display("FAIL reads_rptr[%0d]: got %0d want %0d", i, rptr, i + 1); end
            n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL reads_valid[%0d]: got %b want 1", i, rd_valid); end
            n_cmp++; if (rd_count !== 5'(4 - i)) begin n_bad++; $display("FAIL reads_count[%0d]: got %0d want %0d", i, rd_count, 4 - i); end
        end
        rd_en = 1'b0;
        n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL reads_ae: got %b want 1", almost_empty); end
        tick();
        $display("idle: rptr=%0d rd_valid=%b", rptr, rd_valid);
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reads_valid_drop: got %b want 0", rd_valid); end
        n_cmp++; if (rptr !== 4'd3) begin n_bad++; $display("FAIL reads_rptr_hold: got %0d want 3", rptr); end
    endtask

    task automatic test_wrap();
        logic [3:0] e_ptr;
        logic [4:0] e_gray;
        logic       e_wrap;
        // Advance write pointer to 14 and read back-to-back down to rptr=14.
        wptr_gray = 5'b01001;
        tick(); tick();
        n_cmp++; if (rd_count !== 5'd11) begin n_bad++; $display("FAIL wrap_pre_count: got %0d want 11", rd_count); end
        rd_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            $display("b2b read %0d: rptr=%0d rd_valid=%b rd_count=%0d", i, rptr, rd_valid, rd_count);
            n_cmp++; if (rptr !== 4'(4 + i)) begin n_bad++; $display("FAIL b2b_rptr[%0d]: got %0d want %0d", i, rptr, 4 + i); end
            n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rd_valid); end
            n_cmp++; if (rd_count !== 5'(10 - i)) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, rd_count, 10 - i); end
        end
        rd_en = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_drained_empty: got %b want 1", empty); end
        n_cmp++; if (rptr_gray !== 5'b01001) begin n_bad++; $display("FAIL wrap_gray14: got %b want 01001", rptr_gray); end
        wptr_gray = 5'b11110;
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_lag_empty: got %b want 1", empty); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_lag_valid: got %b want 0", rd_valid); end
        tick();
        n_cmp++; if (rd_count !== 5'd6) begin n_bad++; $display("FAIL wrap_count6: got %0d want 6", rd_count); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            case (i)
                0:       begin e_ptr = 4'd15; e_wrap = 1'b0; e_gray = 5'b01000; end
                1:       begin e_ptr = 4'd0;  e_wrap = 1'b1; e_gray = 5'b11000; end
                default: begin e_ptr = 4'd1;  e_wrap = 1'b1; e_gray = 5'b11001; end
            endcase
            $display("wrap read %0d: rptr=%0d r_wrap=%b rptr_gray=%b rd_count=%0d", i, rptr, r_wrap, rptr_gray, rd_count);
            n_cmp++; if (rptr !== e_ptr) begin n_bad++; $display("FAIL wrap_rptr[%0d]: got %0d want %0d", i, rptr, e_ptr); end
            n_cmp++; if (r_wrap !== e_wrap) begin n_bad++; $display("FAIL wrap_bit[%0d]: got %b want %b", i, r_wrap, e_wrap); end
            n_cmp++; if (rptr_gray !== e_gray) begin n_bad++; $display("FAIL wrap_gray[%0d]: got %b want %b", i, rptr_gray, e_gray); end
            n_cmp++; if (rd_count !== 5'(5 - i)) begin n_bad++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, rd_count, 5 - i); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("drain %0d: rptr=%0d rd_count=%0d", i, rptr, rd_count);
            n_cmp++; if (rd_count !== 5'(2 - i)) begin n_bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, rd_count, 2 - i); end
        end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL uf_pre_empty: got %b want 1", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        $display("read while empty: rptr=%0d rd_valid=%b underflow=%b", rptr, rd_valid, underflow);
        n_cmp++; if (rptr !== 4'd4) begin n_bad++; $display("FAIL uf_rptr: got %0d want 4", rptr); end
        n_cmp++; if (r_wrap !== 1'b1) begin n_bad++; $display("FAIL uf_wrap: got %b want 1", r_wrap); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL uf_valid: got %b want 0", rd_valid); end
        n_cmp++; if (underflow !== UF_EXP) begin n_bad++; $display("FAIL uf_set: got %b want %b", underflow, UF_EXP); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (underflow !== UF_EXP) begin n_bad++; $display("FAIL uf_sticky[%0d]: got %b want %b", i, underflow, UF_EXP); end
        end
        #2 rst_r = 1'b1;
        #1;
        $display("underflow reset: underflow=%b rptr=%0d", underflow, rptr);
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL uf_clear: got %b want 0", underflow); end
        n_cmp++; if (rptr !== 4'd0) begin n_bad++; $display("FAIL uf_rst_rptr: got %0d want 0", rptr); end
        wptr_gray = 5'b00000;
        #1 rst_r = 1'b0;
    endtask

    task automatic test_midop_reset();
        wptr_gray = 5'b01110;
        tick(); tick();
        n_cmp++; if (rd_count !== 5'd11) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 11", rd_count); end
        rd_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            $display("mid read %0d: rptr=%0d rd_count=%0d", i, rptr, rd_count);
        end
        rd_en = 1'b0;
        n_cmp++; if (rptr !== 4'd7) begin n_bad++; $display("FAIL mid_rptr7: got %0d want 7", rptr); end
        n_cmp++; if (rd_count !== 5'd4) begin n_bad++; $display("FAIL mid_count4: got %0d want 4", rd_count); end
        #2 rst_r = 1'b1;
        #1;
        $display("mid reset: rptr=%0d rd_valid=%b empty=%b rd_count=%0d", rptr, rd_valid, empty, rd_count);
        n_cmp++; if (rptr !== 4'd0) begin n_bad++; $display("FAIL mid_rst_rptr: got %0d want 0", rptr); end
        n_cmp++; if (rptr_gray !== 5'b00000) begin n_bad++; $display("FAIL mid_rst_gray: got %b want 00000", rptr_gray); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", rd_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ae: got %b want 1", almost_empty); end
        n_cmp++; if (rd_count !== 5'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", rd_count); end
        #1 rst_r = 1'b0;
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_lag_empty: got %b want 1", empty); end
        tick();
        $display("mid resync: empty=%b rd_count=%0d", empty, rd_count);
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL mid_resync_empty: got %b want 0", empty); end
        n_cmp++; if (rd_count !== 5'd11) begin n_bad++; $display("FAIL mid_resync_count: got %0d want 11", rd_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_sync_lag();
        test_reads();
        test_wrap();
        test_underflow();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
